// File: rtl/spi_vram_bridge_if.sv
// spi_vram_bridge_if: byte-receiver handshake plus VRAM request bus.
// The bridge uses the master modport; the receiver/VRAM side uses slave.
interface spi_vram_bridge_if #(
   parameter int ADDR_W = 13
);
   // SPI receiver side
   logic              ss;
   logic              rx_done;
   logic [7:0]        rx_byte;
   logic [7:0]        tx_byte;
   // VRAM side
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [7:0]        mem_rdata;
   // status
   logic              cmd_err;

   modport master (
      input  ss, rx_done, rx_byte, mem_rdata,
      output tx_byte, mem_addr, mem_wdata, mem_we, mem_re, cmd_err
   );

   modport slave (
      output ss, rx_done, rx_byte, mem_rdata,
      input  tx_byte, mem_addr, mem_wdata, mem_we, mem_re, cmd_err
   );
endinterface

// File: rtl/spi_vram_bridge.sv
// spi_vram_bridge: decodes framed SPI bytes (cmd, addr_hi, addr_lo, data...)
// into single-cycle VRAM write/read strobes with address auto-increment.
// Read-back path (mem_re, RD_LAT return pipeline, tx_byte) is built only
// when the macro VRAM_READBACK_EN is defined; otherwise command 0x02 is
// treated as unknown, mem_re is 0 and tx_byte is 0x00.
// ADDR_W is at most 16: the address is taken from the two address bytes.
module spi_vram_bridge #(
   parameter int ADDR_W = 13,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   spi_vram_bridge_if.master bus
);
   localparam logic [7:0] CMD_WR = 8'h01;
   localparam logic [7:0] CMD_RD = 8'h02;

   typedef enum logic [2:0] {
      ST_CMD,
      ST_ADDR_HI,
      ST_ADDR_LO,
      ST_WR_DATA,
      ST_DISCARD
`ifdef VRAM_READBACK_EN
      ,
      ST_RD_DUMMY,
      ST_RD_DATA
`endif
   } state_t;

   state_t            state, state_next;
   logic              ss_meta, ss_sync;
   logic              accept;
   logic [7:0]        addr_hi, addr_hi_next;
   logic [ADDR_W-1:0] addr, addr_next, addr_load;
   logic [ADDR_W-1:0] mem_addr, mem_addr_next;
   logic [7:0]        mem_wdata, mem_wdata_next;
   logic              mem_we, mem_we_next;
   logic              cmd_err, cmd_err_next;
`ifdef VRAM_READBACK_EN
   logic              is_read, is_read_next;
   logic              mem_re, mem_re_next;
`endif

   // A byte only counts while the frame is open (synchronized ss low).
   assign accept    = bus.rx_done && !ss_sync;
   assign addr_load = ADDR_W'({addr_hi, bus.rx_byte});

   // Two-flop synchronizer for the raw chip-select pin; idles deasserted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_meta <= 1'b1;
         ss_sync <= 1'b1;
      end else begin
         ss_meta <= bus.ss;
         ss_sync <= ss_meta;
      end
   end

   // Next-state and request decode; a byte accepted on the last cycle of a
   // frame is still acted on, and the closed frame then forces ST_CMD.
   always_comb begin
      state_next     = state;
      addr_hi_next   = addr_hi;
      addr_next      = addr;
      mem_addr_next  = mem_addr;
      mem_wdata_next = mem_wdata;
      mem_we_next    = 1'b0;
      cmd_err_next   = 1'b0;
`ifdef VRAM_READBACK_EN
      is_read_next   = is_read;
      mem_re_next    = 1'b0;
`endif
      if (accept) begin
         case (state)
            ST_CMD: begin
               if (bus.rx_byte == CMD_WR) begin
`ifdef VRAM_READBACK_EN
                  is_read_next = 1'b0;
`endif
                  state_next = ST_ADDR_HI;
               end
`ifdef VRAM_READBACK_EN
               else if (bus.rx_byte == CMD_RD) begin
                  is_read_next = 1'b1;
                  state_next   = ST_ADDR_HI;
               end
`endif
               else begin
                  cmd_err_next = 1'b1;
                  state_next   = ST_DISCARD;
               end
            end
            ST_ADDR_HI: begin
               addr_hi_next = bus.rx_byte;
               state_next   = ST_ADDR_LO;
            end
            ST_ADDR_LO: begin
`ifdef VRAM_READBACK_EN
               if (is_read) begin
                  // First read goes out now so tx_byte is ready for the dummy byte.
                  mem_re_next   = 1'b1;
                  mem_addr_next = addr_load;
                  addr_next     = addr_load + ADDR_W'(1);
                  state_next    = ST_RD_DUMMY;
               end else begin
                  addr_next  = addr_load;
                  state_next = ST_WR_DATA;
               end
`else
               addr_next  = addr_load;
               state_next = ST_WR_DATA;
`endif
            end
            ST_WR_DATA: begin
               mem_we_next    = 1'b1;
               mem_wdata_next = bus.rx_byte;
               mem_addr_next  = addr;
               addr_next      = addr + ADDR_W'(1);
            end
`ifdef VRAM_READBACK_EN
            ST_RD_DUMMY: begin
               state_next = ST_RD_DATA;
            end
            ST_RD_DATA: begin
               mem_re_next   = 1'b1;
               mem_addr_next = addr;
               addr_next     = addr + ADDR_W'(1);
            end
`endif
            ST_DISCARD: begin
               state_next = ST_DISCARD;
            end
            default: begin
               state_next = ST_CMD;
            end
         endcase
      end
      if (ss_sync) begin
         state_next = ST_CMD;
      end
   end

   // State, address pointer and registered request outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_CMD;
         addr_hi   <= 8'h00;
         addr      <= '0;
         mem_addr  <= '0;
         mem_wdata <= 8'h00;
         mem_we    <= 1'b0;
         cmd_err   <= 1'b0;
`ifdef VRAM_READBACK_EN
         is_read   <= 1'b0;
         mem_re    <= 1'b0;
`endif
      end else begin
         state     <= state_next;
         addr_hi   <= addr_hi_next;
         addr      <= addr_next;
         mem_addr  <= mem_addr_next;
         mem_wdata <= mem_wdata_next;
         mem_we    <= mem_we_next;
         cmd_err   <= cmd_err_next;
`ifdef VRAM_READBACK_EN
         is_read   <= is_read_next;
         mem_re    <= mem_re_next;
`endif
      end
   end

   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;
   assign bus.mem_we    = mem_we;
   assign bus.cmd_err   = cmd_err;

`ifdef VRAM_READBACK_EN
   // rd_pipe[RD_LAT-1] is high in exactly the cycle mem_rdata is valid.
   logic       rd_pipe [RD_LAT];
   logic [7:0] tx_byte;
   genvar      gi;

   generate
      for (gi = 0; gi < RD_LAT; gi++) begin : g_rd_pipe
         if (gi == 0) begin : g_head
            // First stage follows the registered read strobe.
            always_ff @(posedge clk or posedge rst) begin
               if (rst) rd_pipe[gi] <= 1'b0;
               else     rd_pipe[gi] <= mem_re;
            end
         end else begin : g_tail
            // Later stages delay the strobe one more cycle each.
            always_ff @(posedge clk or posedge rst) begin
               if (rst) rd_pipe[gi] <= 1'b0;
               else     rd_pipe[gi] <= rd_pipe[gi-1];
            end
         end
      end
   endgenerate

   // Capture returning read data; frame end does not cancel a pending return.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   tx_byte <= 8'h00;
      else if (rd_pipe[RD_LAT-1]) tx_byte <= bus.mem_rdata;
   end

   assign bus.mem_re  = mem_re;
   assign bus.tx_byte = tx_byte;
`else
   logic unused_rd;
   assign unused_rd   = ^{bus.mem_rdata, RD_LAT[1:0]};
   assign bus.mem_re  = 1'b0;
   assign bus.tx_byte = 8'h00;
`endif
endmodule

// File: doc/spi_vram_bridge.md
# spi_vram_bridge

Command decoder downstream of the video card's SPI byte receiver. Consumes each received byte (one-cycle `done` strobe plus `dout`), parses a framed command/address/data protocol and turns it into single-cycle VRAM write or read requests with address auto-increment. For reads it supplies the next transmit byte back to the receiver's `din`, so the host MCU can stream VRAM contents out.

## Interface
- `ADDR_W`, 13: VRAM address width; the address is `{addr_hi, addr_lo}[ADDR_W-1:0]`.
- `RD_LAT`, 1: cycles from `mem_re` to valid `mem_rdata`; legal range 1–3.

- `clk` in 1: system clock, the same clock as the SPI receiver.
- `rst` in 1: asynchronous, active-high reset.
- `ss` in 1: raw chip-select pin, active low; 2-FF synchronized internally.
- `rx_done` in 1: one-cycle strobe, byte received.
- `rx_byte` in 8: received byte, valid with `rx_done`.
- `tx_byte` out 8: next byte the receiver shifts out; drives its `din`.
- `mem_addr` out ADDR_W: VRAM address.
- `mem_wdata` out 8: VRAM write data.
- `mem_we` out 1: one-cycle write strobe.
- `mem_re` out 1: one-cycle read strobe.
- `mem_rdata` in 8: read data, valid exactly RD_LAT cycles after `mem_re`.
- `cmd_err` out 1: one-cycle pulse when an unknown command byte is received.

## Operation
- Frame = interval with synchronized `ss` low. Synchronized `ss` high forces state IDLE_CMD within one cycle. Any pending read return still lands in `tx_byte`.
- States: CMD → ADDR_HI → ADDR_LO → {WR_DATA | RD_DUMMY → RD_DATA} or DISCARD. Each transition is taken only on `rx_done`.
- CMD: 0x01 means write and 0x02 means read; the next state is ADDR_HI. Any other byte pulses `cmd_err` and goes to DISCARD until the frame ends.
- ADDR_HI: latch the high byte. ADDR_LO: latch the low byte. For a write, go to WR_DATA. For a read, issue `mem_re` at the latched address, set the address to address+1, and go to RD_DUMMY.
- WR_DATA: each byte → `mem_we`=1, `mem_wdata`=byte, `mem_addr`=current; then address+1. The frame may contain any number of data bytes.
- RD_DUMMY: the host sends one dummy byte; its value is ignored. The receiver loads `tx_byte` (data at the start address) as that byte completes. Next state RD_DATA.
- RD_DATA: each received byte issues `mem_re` at the current address, then address+1. `tx_byte` is refreshed before the following byte boundary.
- Address arithmetic is modulo 2^ADDR_W. The address wraps from all-ones to 0 silently.
- In DISCARD and CMD, `tx_byte` is held.

## Timing
- `rx_done` in cycle T → `mem_we`/`mem_re` registered high in T+1 for exactly one cycle.
- `mem_rdata` is sampled in T+1+RD_LAT → `tx_byte` is updated at T+2+RD_LAT. The SPI byte period (≥16 clk) must exceed RD_LAT+2.
- `cmd_err` is asserted at T+1 for one cycle.
- `rx_done` in the same cycle as synchronized `ss` rising: the byte is fully processed, then state = CMD.
- `rx_done` while synchronized `ss` is high: ignored.
- Reset values: `tx_byte`=0x00, `mem_addr`=0, `mem_wdata`=0x00, `mem_we`=0, `mem_re`=0, `cmd_err`=0, state=CMD, `ss` synchronizer=1.
- Reset mid-read discards the in-flight `mem_rdata`.

## Configuration
- `VRAM_READBACK_EN` defined: full read path as above.
- `VRAM_READBACK_EN` undefined:
  - command 0x02 is unknown (`cmd_err` pulses, then DISCARD);
  - `mem_re` is tied 0;
  - `tx_byte` is constant 0x00;
  - RD_* states and the RD_LAT pipeline are removed.

## Test plan
- Write: frame 0x01,0x12,0x34,0xAA,0xBB → `mem_we` pulses with addr 0x1234/0xAA then 0x1235/0xBB, one cycle each at T+1.
- Read: preload 0x0100=0x5A, 0x0101=0xC3. Frame 0x02,0x01,0x00,dummy,x,x → receiver shifts out 0x5A then 0xC3; `mem_re` at 0x0100, 0x0101, 0x0102.
- Wrap: write frame to addr 0x1FFF (ADDR_W=13) with 2 data bytes → writes at 0x1FFF then 0x0000.
- Bad command: 0x7E,0x01,0x02,0x03 → `cmd_err` single pulse; no `mem_we`/`mem_re` for the rest of the frame. The next frame 0x01,… writes normally.
- Frame abort: raise `ss` after ADDR_HI, then send new frame 0x01,0x00,0x05,0x11 → single write 0x0005=0x11.
- Async reset asserted mid-write frame → all outputs at reset values immediately; the next frame decodes from CMD.
